// File: rtl/axis_packetizer.sv
// axis_packetizer: mesh network-interface transmitter.
// Each accepted request emits one header flit carrying the target/source
// coordinates and payload length. Exactly that many payload flits then pass
// through from the core-side stream, and the final flit is marked with TLAST.
module axis_packetizer #(
  parameter int DATA_WIDTH                    = 32,
  parameter int MAX_ROUTERS_X                 = 4,
  parameter int MAX_ROUTERS_X_WIDTH           = $clog2(MAX_ROUTERS_X),
  parameter int MAX_ROUTERS_Y                 = 4,
  parameter int MAX_ROUTERS_Y_WIDTH           = $clog2(MAX_ROUTERS_Y),
  parameter int MAXIMUM_PACKAGES_NUMBER       = 5,
  parameter int MAXIMUM_PACKAGES_NUMBER_WIDTH = $clog2(MAXIMUM_PACKAGES_NUMBER - 1),
  parameter int ROUTER_X                      = 0,
  parameter int ROUTER_Y                      = 0
`ifndef USE_LIGHT_STREAM
  ,
  parameter int ID_WIDTH                      = 4,
  parameter int DEST_WIDTH                    = 4,
  parameter int USER_WIDTH                    = 4
`endif
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  // packet request
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [MAX_ROUTERS_X_WIDTH-1:0]           req_target_x,
  input  logic [MAX_ROUTERS_Y_WIDTH-1:0]           req_target_y,
  input  logic [MAXIMUM_PACKAGES_NUMBER_WIDTH-1:0] req_length,
  output logic                                     busy,
  // payload stream from the core
  input  logic [DATA_WIDTH-1:0]                    in_tdata,
  input  logic                                     in_tvalid,
  output logic                                     in_tready,
  input  logic                                     in_tlast,
  // flit stream to the router local port
  output logic [DATA_WIDTH-1:0]                    out_tdata,
  output logic                                     out_tvalid,
  input  logic                                     out_tready,
  output logic                                     out_tlast
`ifndef USE_LIGHT_STREAM
  ,
  input  logic [ID_WIDTH-1:0]                      in_tid,
  input  logic [DEST_WIDTH-1:0]                    in_tdest,
  input  logic [USER_WIDTH-1:0]                    in_tuser,
  output logic [ID_WIDTH-1:0]                      out_tid,
  output logic [DEST_WIDTH-1:0]                    out_tdest,
  output logic [USER_WIDTH-1:0]                    out_tuser
`endif
);

  localparam int X_W   = MAX_ROUTERS_X_WIDTH;
  localparam int Y_W   = MAX_ROUTERS_Y_WIDTH;
  localparam int P_W   = MAXIMUM_PACKAGES_NUMBER_WIDTH;
  localparam int HDR_W = 2 * X_W + 2 * Y_W + P_W;

  localparam logic [X_W-1:0] OWN_X = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] OWN_Y = Y_W'(ROUTER_Y);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] target_x_q;
  logic [Y_W-1:0] target_y_q;
  logic [P_W-1:0] length_q;
  logic [P_W-1:0] remaining_q;

  logic [HDR_W-1:0] header_bits;
  logic             payload_beat;
  logic             last_beat;

  // Upstream TLAST is deliberately ignored: the registered length alone
  // delimits the packet. TDEST from the core is replaced by the target.
`ifndef USE_LIGHT_STREAM
  logic unused_in_sideband;
  assign unused_in_sideband = ^{in_tlast, in_tdest};
`else
  logic unused_in_sideband;
  assign unused_in_sideband = in_tlast;
`endif

  // Fields are taken from registers, so the header cannot move while stalled.
  assign header_bits  = {OWN_Y, OWN_X, length_q, target_y_q, target_x_q};
  assign payload_beat = (state_q == PAYLOAD) && in_tvalid && out_tready;
  assign last_beat    = payload_beat && (remaining_q == P_W'(1));
  assign busy         = (state_q != IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)  state_d = HEADER;
      HEADER:  if (out_tready) state_d = (length_q == '0) ? IDLE : PAYLOAD;
      PAYLOAD: if (last_beat)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and payload countdown.
  // NOTE: these are a handful of control registers, not a storage array, so
  // all of them are reset to give defined outputs straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_x_q  <= '0;
      target_y_q  <= '0;
      length_q    <= '0;
      remaining_q <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        target_x_q <= req_target_x;
        target_y_q <= req_target_y;
        length_q   <= req_length;
      end
      if (state_q == HEADER && out_tready) remaining_q <= length_q;
      else if (payload_beat)               remaining_q <= remaining_q - P_W'(1);
    end
  end

  // Output decode: header in HEADER, zero-latency pass-through in PAYLOAD.
  always_comb begin
    req_ready  = 1'b0;
    in_tready  = 1'b0;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    out_tdata  = '0;
`ifndef USE_LIGHT_STREAM
    out_tid    = '0;
    out_tuser  = '0;
    out_tdest  = DEST_WIDTH'({target_y_q, target_x_q});
`endif
    case (state_q)
      IDLE: req_ready = 1'b1;
      HEADER: begin
        out_tvalid = 1'b1;
        out_tlast  = (length_q == '0);
        out_tdata  = DATA_WIDTH'(header_bits);
      end
      PAYLOAD: begin
        out_tvalid = in_tvalid;
        in_tready  = out_tready;
        out_tlast  = (remaining_q == P_W'(1));
        out_tdata  = in_tdata;
`ifndef USE_LIGHT_STREAM
        out_tid    = in_tid;
        out_tuser  = in_tuser;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

Network-interface transmitter that injects packets into a mesh router's local input port. On each request it builds the header flit that router arbiters decode: target X, target Y and the count of following flits. It then forwards exactly that many payload flits from an AXI-Stream source and marks the final flit with TLAST. It sits between a core-side DMA or store unit and the router's local `axis_if` slave port.

## Interface
- `DATA_WIDTH`, 32, flit width; must be ≥ 2·X_W + 2·Y_W + P_W.
- `ID_WIDTH` / `DEST_WIDTH` / `USER_WIDTH`, 4 each, sideband widths. Present only when `USE_LIGHT_STREAM` is not defined.
- `MAX_ROUTERS_X`, 4, mesh width; `MAX_ROUTERS_X_WIDTH` (X_W) = $clog2(MAX_ROUTERS_X).
- `MAX_ROUTERS_Y`, 4, mesh height; `MAX_ROUTERS_Y_WIDTH` (Y_W) = $clog2(MAX_ROUTERS_Y).
- `MAXIMUM_PACKAGES_NUMBER`, 5; `MAXIMUM_PACKAGES_NUMBER_WIDTH` (P_W) = $clog2(MAXIMUM_PACKAGES_NUMBER-1).
- `ROUTER_X`, 0, own X coordinate; `ROUTER_Y`, 0, own Y coordinate.
- Reset is `rst_n`: asynchronous, active-low. Clock is `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  packet request valid
- `req_ready`  out  1  request accepted when both are high
- `req_target_x`  in  X_W  destination X
- `req_target_y`  in  Y_W  destination Y
- `req_length`  in  P_W  payload flit count; 0..2^P_W−1 are all legal, and 0 means header-only
- `in`  axis_if.s  —  payload stream from the core
- `out`  axis_if.m  —  flit stream to the router local port
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, HEADER, PAYLOAD.
- **IDLE**
  - `req_ready`=1; `out.TVALID`=0; `in.TREADY`=0.
  - On `req_valid & req_ready`: register target_x, target_y and length, then go to HEADER.
- **HEADER** header flit layout:
  - [X_W−1:0] = target_x
  - [X_W+Y_W−1:X_W] = target_y
  - [X_W+Y_W+P_W−1:X_W+Y_W] = length
  - next X_W bits = ROUTER_X
  - next Y_W bits = ROUTER_Y
  - all remaining bits = 0
- **HEADER** signalling:
  - `out.TVALID`=1; `out.TLAST` = (length==0).
  - Sideband: TID=0, TUSER=0, TDEST={target_y,target_x} zero-extended.
  - On `out.TREADY`: go to IDLE if length==0; otherwise load `remaining`=length and go to PAYLOAD.
- **PAYLOAD**
  - Pass-through: `out.TVALID`=`in.TVALID`, `in.TREADY`=`out.TREADY`, TDATA/TID/TUSER from `in`. TDEST held as in HEADER.
  - `out.TLAST` = (remaining==1).
  - Each beat (`in.TVALID & out.TREADY`) decrements `remaining`. The beat with remaining==1 returns the FSM to IDLE.
- Upstream `in.TLAST` is ignored; the registered length alone delimits the packet.
- Header fields are stable for the whole packet. `req_*` inputs may change freely once the request is accepted.
- The header does not change while `out.TVALID`=1 and `out.TREADY`=0 (AXI-Stream stability).

## Timing
- Reset values: state=IDLE, `req_ready`=1, `busy`=0, `out.TVALID`=0, `out.TLAST`=0, `in.TREADY`=0, `remaining`=0, registered fields=0.
- Request accepted in cycle N: header valid in N+1, and `busy` rises in N+1.
- Header handshake in cycle M: first payload beat is possible in M+1, since pass-through adds no latency.
- Last payload handshake in cycle L: IDLE in L+1, where the next request can be accepted. Its header is valid at L+2 earliest, giving one bubble between packets.
- Header-only packet: one flit with TLAST=1; the FSM is back in IDLE the next cycle.
- Backpressure: `out.TREADY`=0 stalls any state with no loss or duplication. `in.TVALID` gaps insert idle cycles with `out.TVALID`=0.
- Asynchronous reset mid-packet: forces IDLE immediately and drops `out.TVALID`. The partial packet is abandoned and no TLAST is emitted.

## Test plan
Parameters for all scenarios: defaults, ROUTER_X=1, ROUTER_Y=2.
- **Single packet:** request target (3,1), length 2; payload 0xA, 0xB.
  - Required: header 0x267 with TLAST=0, then 0xA (TLAST=0), then 0xB (TLAST=1). `busy` falls the cycle after 0xB.
- **Header-only:** request target (0,0), length 0.
  - Required: single flit 0x240 with TLAST=1; `in.TREADY` never asserts.
- **Backpressure:** `out.TREADY` toggles 1010… during a length-3 packet.
  - Required: exactly 4 flits, each held stable while stalled; TLAST only on the 4th.
- **Source gaps:** `in.TVALID` low for 3 cycles mid-payload.
  - Required: `out.TVALID` low for the same 3 cycles; `remaining` unchanged.
- **Back-to-back:** `req_valid` held high for two length-1 requests.
  - Required: second header appears exactly 2 cycles after the first packet's last beat; `req_ready` low from the first acceptance until IDLE.
- **Reset mid-payload:** assert `rst_n`=0 after 1 of 3 payload beats.
  - Required: all outputs at reset values in the same cycle; a new request after reset produces a correct fresh header.
